// File: rtl/iob_acc_seq_pkg.sv
// rtl/iob_acc_seq_pkg.sv - shared widths and FSM state encodings for the loop sequencer
package iob_acc_seq_pkg;

    localparam int SEQ_DATA_W = 21;
    localparam int SEQ_CNT_W  = 16;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE = 2'd0;
    localparam seq_state_t ST_RUN  = 2'd1;
    localparam seq_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/iob_acc_seq_if.sv
// rtl/iob_acc_seq_if.sv - config, address handshake, status and accumulator-control bundle
interface iob_acc_seq_if
    import iob_acc_seq_pkg::*;
#(
    parameter int DATA_W = SEQ_DATA_W,
    parameter int CNT_W  = SEQ_CNT_W
);
    logic              start;
    logic [DATA_W-1:0] start_val;
    logic [DATA_W-1:0] stride;
    logic [DATA_W-1:0] shift;
    logic [CNT_W-1:0]  iter;
    logic [CNT_W-1:0]  per;
    logic              ready;
    logic              valid;
    logic              last;
    logic              busy;
    logic              done;
    logic              acc_en;
    logic              acc_ld;
    logic [DATA_W-1:0] acc_ld_val;
    logic [DATA_W-1:0] acc_incr;

    modport master (
        input  start, start_val, stride, shift, iter, per, ready,
        output valid, last, busy, done, acc_en, acc_ld, acc_ld_val, acc_incr
    );

    modport slave (
        output start, start_val, stride, shift, iter, per, ready,
        input  valid, last, busy, done, acc_en, acc_ld, acc_ld_val, acc_incr
    );

endinterface

// File: rtl/iob_acc_seq_cnt.sv
// rtl/iob_acc_seq_cnt.sv - nested inner/outer loop counter with row-end and last flags
module iob_acc_seq_cnt
    import iob_acc_seq_pkg::*;
#(
    parameter int CNT_W = SEQ_CNT_W
) (
    input  logic             clk_i,
    input  logic             cke_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             step_i,
    input  logic [CNT_W-1:0] iter_i,
    input  logic [CNT_W-1:0] per_i,
    output logic             row_end_o,
    output logic             last_o
);

    logic [CNT_W-1:0] j_q;
    logic [CNT_W-1:0] i_q;

    // iter_i/per_i are latched nonzero whenever step_i can fire, so the -1 never underflows in use
    assign row_end_o = (j_q == (iter_i - 1'b1));
    assign last_o    = row_end_o && (i_q == (per_i - 1'b1));

    // j walks the row; at row end it wraps and i advances to the next row
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            j_q <= '0;
            i_q <= '0;
        end else if (cke_i) begin
            if (clr_i) begin
                j_q <= '0;
                i_q <= '0;
            end else if (step_i) begin
                if (row_end_o) begin
                    j_q <= '0;
                    i_q <= i_q + 1'b1;
                end else begin
                    j_q <= j_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/iob_acc_seq.sv
// rtl/iob_acc_seq.sv - two-level loop sequencer driving an external load/increment accumulator
module iob_acc_seq
    import iob_acc_seq_pkg::*;
#(
    parameter int DATA_W = SEQ_DATA_W,
    parameter int CNT_W  = SEQ_CNT_W
) (
    input  logic         clk_i,
    input  logic         cke_i,
    input  logic         rst_i,
    iob_acc_seq_if.master bus
);

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic [DATA_W-1:0] stride_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] row_base_q;
    logic [CNT_W-1:0]  iter_q;
    logic [CNT_W-1:0]  per_q;
    logic [DATA_W-1:0] next_row;
    logic              cfg_ok;
    logic              accept;
    logic              beat;
    logic              row_end;
    logic              seq_last;
    logic              acc_en;
    logic              acc_ld;
    logic [DATA_W-1:0] acc_ld_val;

    assign cfg_ok   = (bus.iter != '0) && (bus.per != '0);
    assign accept   = (state_q == ST_IDLE) && bus.start;
    assign beat     = (state_q == ST_RUN) && bus.ready;
    assign next_row = row_base_q + shift_q;

    iob_acc_seq_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_i     (clk_i),
        .cke_i     (cke_i),
        .rst_i     (rst_i),
        .clr_i     (accept),
        .step_i    (beat),
        .iter_i    (iter_q),
        .per_i     (per_q),
        .row_end_o (row_end),
        .last_o    (seq_last)
    );

    // Next state plus the Mealy accumulator controls; the address lands one cycle after acc_en
    always_comb begin
        state_d    = state_q;
        acc_en     = 1'b0;
        acc_ld     = 1'b0;
        acc_ld_val = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (cfg_ok) begin
                        acc_en     = 1'b1;
                        acc_ld     = 1'b1;
                        acc_ld_val = bus.start_val;
                        state_d    = ST_RUN;
                    end else begin
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (bus.ready) begin
                    if (seq_last) begin
                        state_d = ST_DONE;
                    end else if (row_end) begin
                        acc_en     = 1'b1;
                        acc_ld     = 1'b1;
                        acc_ld_val = next_row;
                    end else begin
                        acc_en = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (!cke_i) begin
            acc_en     = 1'b0;
            acc_ld     = 1'b0;
            acc_ld_val = '0;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else if (cke_i) begin
            state_q <= state_d;
        end
    end

    // Loop config is captured only on an accepted start; row base moves on every row-end beat
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stride_q   <= '0;
            shift_q    <= '0;
            iter_q     <= '0;
            per_q      <= '0;
            row_base_q <= '0;
        end else if (cke_i) begin
            if (accept && cfg_ok) begin
                stride_q   <= bus.stride;
                shift_q    <= bus.shift;
                iter_q     <= bus.iter;
                per_q      <= bus.per;
                row_base_q <= bus.start_val;
            end else if (beat && row_end && !seq_last) begin
                row_base_q <= next_row;
            end
        end
    end

    assign bus.valid      = (state_q == ST_RUN);
    assign bus.last       = (state_q == ST_RUN) && seq_last;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.acc_en     = acc_en;
    assign bus.acc_ld     = acc_ld;
    assign bus.acc_ld_val = acc_ld_val;
    assign bus.acc_incr   = stride_q;

endmodule
